// File: rtl/aqp_esp_uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// aqp_esp_uart_tx_arbiter_if
//   Byte-stream handshake between a requester and the ESP UART TX arbiter.
//   The requester (master) holds data/valid/last stable until ready is seen.
//
//   data  [7:0]  byte to transmit
//   valid        data is valid
//   last         byte is the final byte of its packet
//   ready        byte accepted this cycle (driven by the arbiter)
// -----------------------------------------------------------------------------
interface aqp_esp_uart_tx_arbiter_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, valid, last, input  ready);
  modport slave  (input  data, valid, last, output ready);
endinterface

// File: rtl/aqp_esp_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// aqp_esp_uart_tx_arbiter
//   Shares the ESP UART TX byte channel between the CPU I/O port (req0) and
//   the debug/monitor engine (req1). Ownership is packet-granular: once
//   granted, a requester keeps the channel until its byte flagged last has
//   been transferred, or until it has kept valid low for LOCK_TIMEOUT cycles
//   while owning the channel (forced release, one-cycle timeout pulse).
//   Bytes pass through combinationally while BUSY, so there is no added
//   latency; deciding a new owner costs one idle cycle.
//
// Parameters
//   LOCK_TIMEOUT  stall cycles tolerated before forced release (1..65535)
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   req0, req1     requester byte streams (slave modport)
//   tx_data/valid  byte towards the UART TX serializer
//   tx_ready       serializer accepts the byte
//   grant[1:0]     one-hot current owner, 2'b00 when idle
//   timeout        one-cycle pulse on forced release
//
// Build option
//   AQP_ESP_UART_TX_ARB_PRIO_EN  when defined, req0 wins every arbitration
//                                in which it is valid (strict priority);
//                                otherwise ties alternate round-robin.
// -----------------------------------------------------------------------------
module aqp_esp_uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1023
) (
  input  logic                            clk,
  input  logic                            reset_n,
  aqp_esp_uart_tx_arbiter_if.slave        req0,
  aqp_esp_uart_tx_arbiter_if.slave        req1,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic [1:0]                      grant,
  output logic                            timeout
);

  localparam int NUM_REQ = 2;
  // Stall count at which the next stalled cycle forces release.
  localparam logic [15:0] STALL_LAST = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  // Requesters gathered into arrays so the owner can index them directly.
  logic [NUM_REQ-1:0][7:0] rq_data;
  logic [NUM_REQ-1:0]      rq_valid;
  logic [NUM_REQ-1:0]      rq_last;
  logic [NUM_REQ-1:0]      rq_ready;

  assign rq_data  = {req1.data,  req0.data};
  assign rq_valid = {req1.valid, req0.valid};
  assign rq_last  = {req1.last,  req0.last};
  assign req0.ready = rq_ready[0];
  assign req1.ready = rq_ready[1];

  logic [7:0] own_data;
  logic       own_valid;
  logic       own_last;
  logic       xfer;

  assign own_data  = rq_data[owner_q];
  assign own_valid = rq_valid[owner_q];
  assign own_last  = rq_last[owner_q];
  assign xfer      = (state_q == BUSY) && own_valid && tx_ready;

  // Winner of an IDLE arbitration; only meaningful when some valid is high.
  logic pick;

  always_comb begin
`ifdef AQP_ESP_UART_TX_ARB_PRIO_EN
    pick = ~rq_valid[0];
`else
    if (&rq_valid) pick = ~last_owner_q;
    else           pick = ~rq_valid[0];
`endif
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;   // req0 wins the first tie
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    stall_cnt_d  = stall_cnt_q;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|rq_valid) begin
          state_d     = BUSY;
          owner_d     = pick;
          stall_cnt_d = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          // A moving byte always resets the stall window; a timeout can only
          // fire with valid low, so it never collides with a transfer.
          stall_cnt_d = '0;
          if (own_last) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end else if (!own_valid) begin
          if (stall_cnt_q == STALL_LAST) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            stall_cnt_d  = '0;
            timeout_d    = 1'b1;
          end else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
        // valid high with tx_ready low is serializer backpressure: hold.
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational pass-through from the owner while BUSY.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    rq_ready = '0;
    grant    = '0;
    if (state_q == BUSY) begin
      tx_data           = own_data;
      tx_valid          = own_valid;
      rq_ready[owner_q] = tx_ready;
      grant[owner_q]    = 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_aqp_esp_uart_tx_arbiter.sv
module tb_aqp_esp_uart_tx_arbiter;
  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [1:0] grant;
  logic       timeout;

  aqp_esp_uart_tx_arbiter_if r0_if();
  aqp_esp_uart_tx_arbiter_if r1_if();

  aqp_esp_uart_tx_arbiter #(.LOCK_TIMEOUT(LT)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (r0_if),
    .req1     (r1_if),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant    (grant),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [1:0] g, bit tv, logic [7:0] td,
                         bit r0, bit r1, bit to);
    chk({tag, ".grant"},    {6'b0, grant},        {6'b0, g});
    chk({tag, ".tx_valid"}, {7'b0, tx_valid},     {7'b0, tv});
    chk({tag, ".tx_data"},  tx_data,              td);
    chk({tag, ".r0_ready"}, {7'b0, r0_if.ready},  {7'b0, r0});
    chk({tag, ".r1_ready"}, {7'b0, r1_if.ready},  {7'b0, r1});
    chk({tag, ".timeout"},  {7'b0, timeout},      {7'b0, to});
  endtask

  task automatic drive(bit v0, bit l0, logic [7:0] d0,
                       bit v1, bit l1, logic [7:0] d1, bit rdy);
    r0_if.valid = v0; r0_if.last = l0; r0_if.data = d0;
    r1_if.valid = v1; r1_if.last = l1; r1_if.data = d1;
    tx_ready    = rdy;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    cyc();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         rst;
    bit         v0, l0; logic [7:0] d0;
    bit         v1, l1; logic [7:0] d1;
    bit         rdy;
    logic [1:0] g; bit tv; logic [7:0] td; bit r0, r1, to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit v0, bit l0, logic [7:0] d0,
                              bit v1, bit l1, logic [7:0] d1, bit rdy,
                              logic [1:0] g, bit tv, logic [7:0] td,
                              bit r0, bit r1, bit to);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.l0 = l0; v.d0 = d0;
    v.v1 = v1; v.l1 = l1; v.d1 = d1; v.rdy = rdy;
    v.g = g; v.tv = tv; v.td = td; v.r0 = r0; v.r1 = r1; v.to = to;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model for the random phase, in packet/ownership terms.
  // ---------------------------------------------------------------------------
  int m_owner = -1;   // -1 = nobody holds the channel
  int m_last  = 1;    // requester that owned the previous packet
  int m_stall = 0;    // cycles the owner has left valid low since its last byte
  bit m_to    = 1'b0;

  function automatic int choose(bit v0, bit v1, int last);
`ifdef AQP_ESP_UART_TX_ARB_PRIO_EN
    if (v0) return 0;
    return 1;
`else
    if (v0 && v1) return (last == 0) ? 1 : 0;
    return v0 ? 0 : 1;
`endif
  endfunction

  bit         dv[2], dl[2];
  logic [7:0] dd[2];
  int         left[2], gap[2];
  bit         rdy_r;

  task automatic rnd_update(bit acc0, bit acc1);
    bit acc[2];
    acc[0] = acc0; acc[1] = acc1;
    for (int k = 0; k < 2; k++) begin
      if (dv[k] && acc[k]) begin
        left[k]--;
        dv[k] = 1'b0;
        if (left[k] == 0) gap[k] = int'($urandom_range(0, 3));
        else if ($urandom_range(0, 5) == 0) gap[k] = int'($urandom_range(1, 20));
        else gap[k] = 0;
      end
      if (!dv[k]) begin
        if (gap[k] > 0) gap[k]--;
        else begin
          if (left[k] == 0) left[k] = int'($urandom_range(1, 4));
          dv[k] = 1'b1;
          dd[k] = 8'($urandom);
          dl[k] = (left[k] == 1);
        end
      end
    end
    rdy_r = ($urandom_range(0, 3) != 0);
    drive(dv[0], dl[0], dd[0], dv[1], dl[1], dd[1], rdy_r);
  endtask

  logic [7:0] got[$];

  task automatic capture();
    if (tx_valid && tx_ready) got.push_back(tx_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 2'b00, 0, 8'h00, 0, 0, 0);

    // Single requester: A1,A2,A3 then contention from a fresh reset.
    vecs.push_back(mk(1, 1,0,8'hA1, 0,0,8'h00, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'hA1, 0,0,8'h00, 1,  2'b01,1,8'hA1,1,0,0));
    vecs.push_back(mk(1, 1,0,8'hA2, 0,0,8'h00, 1,  2'b01,1,8'hA2,1,0,0));
    vecs.push_back(mk(1, 1,1,8'hA3, 0,0,8'h00, 1,  2'b01,1,8'hA3,1,0,0));
    vecs.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(0, 1,0,8'h10, 1,0,8'h20, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b01,1,8'h10,1,0,0));
    vecs.push_back(mk(1, 1,1,8'h11, 1,0,8'h20, 1,  2'b01,1,8'h11,1,0,0));
`ifdef AQP_ESP_UART_TX_ARB_PRIO_EN
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b01,1,8'h10,1,0,0));
    vecs.push_back(mk(1, 1,1,8'h11, 1,0,8'h20, 1,  2'b01,1,8'h11,1,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 0,  2'b01,1,8'h10,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b01,1,8'h10,1,0,0));
    vecs.push_back(mk(1, 1,1,8'h11, 1,0,8'h20, 1,  2'b01,1,8'h11,1,0,0));
    vecs.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 1,  2'b00,0,8'h00,0,0,0));
`else
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,0,8'h20, 1,  2'b10,1,8'h20,0,1,0));
    vecs.push_back(mk(1, 1,0,8'h10, 1,1,8'h21, 1,  2'b10,1,8'h21,0,1,0));
    vecs.push_back(mk(1, 1,0,8'h10, 0,0,8'h00, 1,  2'b00,0,8'h00,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 0,0,8'h00, 0,  2'b01,1,8'h10,0,0,0));
    vecs.push_back(mk(1, 1,0,8'h10, 0,0,8'h00, 1,  2'b01,1,8'h10,1,0,0));
    vecs.push_back(mk(1, 1,1,8'h11, 0,0,8'h00, 1,  2'b01,1,8'h11,1,0,0));
    vecs.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 1,  2'b00,0,8'h00,0,0,0));
`endif

    foreach (vecs[i]) begin
      cyc();
      reset_n = vecs[i].rst;
      drive(vecs[i].v0, vecs[i].l0, vecs[i].d0,
            vecs[i].v1, vecs[i].l1, vecs[i].d1, vecs[i].rdy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].tv, vecs[i].td,
              vecs[i].r0, vecs[i].r1, vecs[i].to);
    end

    // Backpressure: 50 cycles of tx_ready low mid-packet, no timeout, no loss.
    do_reset();
    got.delete();
    drive(1, 0, 8'hB0, 0, 0, 8'h00, 1);
    @(negedge clk); capture();
    cyc();
    @(negedge clk); capture();
    chk("bp.grant", {6'b0, grant}, 8'h01);
    cyc();
    drive(1, 0, 8'hB1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); capture();
      chk("bp.timeout", {7'b0, timeout}, 8'h00);
      chk("bp.hold_grant", {6'b0, grant}, 8'h01);
      cyc();
    end
    drive(1, 0, 8'hB1, 0, 0, 8'h00, 1);
    @(negedge clk); capture();
    cyc();
    drive(1, 1, 8'hB2, 0, 0, 8'h00, 1);
    @(negedge clk); capture();
    cyc();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
    @(negedge clk);
    chk("bp.release", {6'b0, grant}, 8'h00);
    chk("bp.count", 8'(got.size()), 8'd3);
    if (got.size() == 3) begin
      chk("bp.byte0", got[0], 8'hB0);
      chk("bp.byte1", got[1], 8'hB1);
      chk("bp.byte2", got[2], 8'hB2);
    end

    // Stall: req1 drops valid after its first byte, req0 waits.
    cyc();
    drive(0, 0, 8'h00, 1, 0, 8'hC0, 1);
    @(negedge clk);
    chk("stall.idle", {6'b0, grant}, 8'h00);
    cyc();
    @(negedge clk);
    chk("stall.own", {6'b0, grant}, 8'h02);
    chk("stall.c0", tx_data, 8'hC0);
    cyc();
    drive(1, 1, 8'hD0, 0, 0, 8'h00, 1);
    for (int k = 1; k <= LT; k++) begin
      @(negedge clk);
      chk($sformatf("stall.no_to%0d", k), {7'b0, timeout}, 8'h00);
      chk($sformatf("stall.grant%0d", k), {6'b0, grant}, 8'h02);
      chk($sformatf("stall.r0_%0d", k), {7'b0, r0_if.ready}, 8'h00);
      cyc();
    end
    @(negedge clk);
    chk("stall.timeout", {7'b0, timeout}, 8'h01);
    chk("stall.released", {6'b0, grant}, 8'h00);
    cyc();
    @(negedge clk);
    chk("stall.pulse_end", {7'b0, timeout}, 8'h00);
    chk("stall.next_grant", {6'b0, grant}, 8'h01);
    chk("stall.d0", tx_data, 8'hD0);
    cyc();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
    @(negedge clk);
    chk("stall.idle_after", {6'b0, grant}, 8'h00);

    // Reset mid-packet: req0 owned the last packet, so only reset makes it win.
    cyc();
    drive(1, 0, 8'hE0, 0, 0, 8'h00, 1);
    cyc();
    cyc();
    drive(1, 0, 8'hE1, 0, 0, 8'h00, 1);
    cyc();
    drive(1, 0, 8'hE2, 1, 0, 8'hF0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst.async", 2'b00, 0, 8'h00, 0, 0, 0);
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk_all("rst.idle", 2'b00, 0, 8'h00, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk_all("rst.tie", 2'b01, 1, 8'hE2, 1, 0, 0);

    // Random traffic against the model.
    do_reset();
    m_owner = -1; m_last = 1; m_stall = 0; m_to = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dv[k] = 0; dl[k] = 0; dd[k] = 8'h00; left[k] = 0; gap[k] = 0;
    end
    rnd_update(0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] eg;
      bit         etv, er0, er1, nto;
      logic [7:0] etd;
      @(negedge clk);
      eg = 2'b00; etv = 0; etd = 8'h00; er0 = 0; er1 = 0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        etv = dv[m_owner];
        etd = dd[m_owner];
        er0 = (m_owner == 0) && rdy_r;
        er1 = (m_owner == 1) && rdy_r;
      end
      chk_all($sformatf("rnd%0d", i), eg, etv, etd, er0, er1, m_to);
      nto = 1'b0;
      if (m_owner < 0) begin
        if (dv[0] || dv[1]) begin
          m_owner = choose(dv[0], dv[1], m_last);
          m_stall = 0;
        end
      end else if (dv[m_owner] && rdy_r) begin
        m_stall = 0;
        if (dl[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (!dv[m_owner]) begin
        m_stall++;
        if (m_stall == LT) begin
          nto     = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
          m_stall = 0;
        end
      end
      m_to = nto;
      cyc();
      rnd_update(dv[0] && er0, dv[1] && er1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
